// File: rtl/scan_pkg.sv
// Shared encodings and the index stepping rule for the scan sequencer.
// The stepping rule lives here so the sequencer reads as pure control flow.
package scan_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0] idx;
        logic       dir_up;
        logic       wrap;
    } step_t;

    localparam logic [2:0] IDX_MIN = 3'd0;
    localparam logic [2:0] IDX_MAX = 3'd7;

    // Next index/direction for one step; mode 11 falls through to counting up.
    function automatic step_t next_step(input logic [2:0] idx,
                                        input logic       dir_up,
                                        input logic [1:0] mode);
        step_t r;
        r.idx    = idx;
        r.dir_up = dir_up;
        r.wrap   = 1'b0;
        case (mode)
            MODE_DOWN: begin
                r.idx  = idx - 3'd1;
                r.wrap = (idx == IDX_MIN);
            end
            MODE_BOUNCE: begin
                if (dir_up) begin
                    if (idx == IDX_MAX) begin
                        r.idx    = idx - 3'd1;
                        r.dir_up = 1'b0;
                    end else begin
                        r.idx = idx + 3'd1;
                    end
                end else begin
                    if (idx == IDX_MIN) begin
                        r.idx    = idx + 3'd1;
                        r.dir_up = 1'b1;
                    end else begin
                        r.idx  = idx - 3'd1;
                        r.wrap = (idx == 3'd1);
                    end
                end
            end
            // NOTE: every path assigns every field (defaults above plus a
            // default branch), so this logic can never infer a latch.
            default: begin
                r.idx  = idx + 3'd1;
                r.wrap = (idx == IDX_MAX);
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler: down-counter that ticks once every div+1 enabled cycles.
// reload restarts the period from div; div is only sampled on reload or wrap.
module tick_divider
    import scan_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             reload,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;

    assign tick = en && !reload && (count_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (reload) begin
            count_q <= div;
        end else if (en) begin
            if (count_q == '0) begin
                count_q <= div;
            end else begin
                count_q <= count_q - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// 3-bit scan index sequencer (up/down/bounce) driving a 3-to-8 decoder select.
// All outputs come straight from flops; the prescaler sets the step rate.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [2:0]       load_val,
    input  logic [DIV_W-1:0] div,
    output logic             A2,
    output logic             A1,
    output logic             A0,
    output logic             step,
    output logic             wrap,
    output logic             busy
);

    state_e     state_q;
    logic [2:0] index_q;
    logic       dir_up_q;
    logic       oneshot_q;
    logic       step_q;
    logic       wrap_q;

    logic       start_ok;
    logic       reload;
    logic       tick;
    step_t      nxt;

    assign start_ok = (state_q == ST_IDLE) && start && !stop;
    assign reload   = load || start_ok;
    assign nxt      = next_step(index_q, dir_up_q, mode);

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q == ST_RUN),
        .reload (reload),
        .div    (div),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            index_q   <= IDX_MIN;
            dir_up_q  <= 1'b1;
            oneshot_q <= 1'b0;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            if (load) begin
                // Load wins over a due step; a coinciding stop still halts.
                index_q  <= load_val;
                dir_up_q <= 1'b1;
                if (stop) begin
                    state_q <= ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_ok) begin
                            state_q   <= ST_RUN;
                            oneshot_q <= oneshot;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            state_q <= ST_IDLE;
                        end else if (tick) begin
                            index_q  <= nxt.idx;
                            dir_up_q <= nxt.dir_up;
                            step_q   <= 1'b1;
                            wrap_q   <= nxt.wrap;
                            if (nxt.wrap && oneshot_q) begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign A2   = index_q[2];
    assign A1   = index_q[1];
    assign A0   = index_q[0];
    assign step = step_q;
    assign wrap = wrap_q;
    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: a vector table plus hand sequences for
// bounce timing, load-over-step and asynchronous reset.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       oneshot = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic [7:0] div = 8'd0;
    logic       A2, A1, A0, step, wrap, busy;

    int n_vec = 0;
    int n_bad = 0;

    scan_sequencer #(.DIV_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .oneshot  (oneshot),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .div      (div),
        .A2       (A2),
        .A1       (A1),
        .A0       (A0),
        .step     (step),
        .wrap     (wrap),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, stop, oneshot;
        logic [1:0] mode;
        logic       load;
        logic [2:0] load_val;
        logic [7:0] div;
        logic [2:0] e_idx;
        logic       e_step, e_wrap, e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic sp, logic os, logic [1:0] md,
                                logic ld, logic [2:0] lv, logic [7:0] dv,
                                logic [2:0] ei, logic es, logic ew, logic eb);
        vec_t v;
        v.start = st; v.stop = sp; v.oneshot = os; v.mode = md;
        v.load = ld; v.load_val = lv; v.div = dv;
        v.e_idx = ei; v.e_step = es; v.e_wrap = ew; v.e_busy = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [2:0] ei,
                         input logic es, input logic ew, input logic eb);
        n_vec++;
        if ({A2, A1, A0, step, wrap, busy} !== {ei, es, ew, eb}) begin
            n_bad++;
            $display("FAIL %s: got idx=%0d step=%b wrap=%b busy=%b, expected idx=%0d step=%b wrap=%b busy=%b",
                     name, {A2, A1, A0}, step, wrap, busy, ei, es, ew, eb);
        end
    endtask

    // Drive one cycle of inputs, then sample #1 after the rising edge.
    task automatic apply(input logic st, input logic sp, input logic os,
                         input logic [1:0] md, input logic ld,
                         input logic [2:0] lv, input logic [7:0] dv);
        start = st; stop = sp; oneshot = os; mode = md;
        load = ld; load_val = lv; div = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // up, div=0: start then 1..7,0
        vecs.push_back(mk(1,0,0,2'd0,0,3'd0,8'd0, 3'd0,0,0,1));
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(0,0,0,2'd0,0,3'd0,8'd0, 3'(i),1,0,1));
        vecs.push_back(mk(0,0,0,2'd0,0,3'd0,8'd0, 3'd0,1,1,1));
        vecs.push_back(mk(0,1,0,2'd0,0,3'd0,8'd0, 3'd0,0,0,0));
        // start and stop together from IDLE
        vecs.push_back(mk(1,1,0,2'd0,0,3'd0,8'd0, 3'd0,0,0,0));
        vecs.push_back(mk(0,0,0,2'd0,0,3'd0,8'd0, 3'd0,0,0,0));
        // oneshot down from 3
        vecs.push_back(mk(0,0,0,2'd1,1,3'd3,8'd0, 3'd3,0,0,0));
        vecs.push_back(mk(1,0,1,2'd1,0,3'd0,8'd0, 3'd3,0,0,1));
        vecs.push_back(mk(0,0,0,2'd1,0,3'd0,8'd0, 3'd2,1,0,1));
        vecs.push_back(mk(0,0,0,2'd1,0,3'd0,8'd0, 3'd1,1,0,1));
        vecs.push_back(mk(0,0,0,2'd1,0,3'd0,8'd0, 3'd0,1,0,1));
        vecs.push_back(mk(0,0,0,2'd1,0,3'd0,8'd0, 3'd7,1,1,0));
        vecs.push_back(mk(0,0,0,2'd1,0,3'd0,8'd0, 3'd7,0,0,0));
        // mode 11 counts up, continuous
        vecs.push_back(mk(0,0,0,2'd3,1,3'd6,8'd0, 3'd6,0,0,0));
        vecs.push_back(mk(1,0,0,2'd3,0,3'd0,8'd0, 3'd6,0,0,1));
        vecs.push_back(mk(0,0,0,2'd3,0,3'd0,8'd0, 3'd7,1,0,1));
        vecs.push_back(mk(0,0,0,2'd3,0,3'd0,8'd0, 3'd0,1,1,1));
        // stop and load together
        vecs.push_back(mk(0,1,0,2'd0,1,3'd4,8'd0, 3'd4,0,0,0));
        // start again; start while running is ignored
        vecs.push_back(mk(1,0,0,2'd0,0,3'd0,8'd0, 3'd4,0,0,1));
        vecs.push_back(mk(1,0,0,2'd0,0,3'd0,8'd0, 3'd5,1,0,1));
        vecs.push_back(mk(0,1,0,2'd0,0,3'd0,8'd0, 3'd5,0,0,0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 3'd0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 3'd0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].start, vecs[i].stop, vecs[i].oneshot, vecs[i].mode,
                  vecs[i].load, vecs[i].load_val, vecs[i].div);
            check($sformatf("vec%0d", i), vecs[i].e_idx, vecs[i].e_step,
                  vecs[i].e_wrap, vecs[i].e_busy);
        end

        // bounce, div=2, from 0: one step every 3 cycles, wrap only on 1->0
        begin
            logic [2:0] seq [14];
            logic [2:0] prev;
            seq = '{3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0};
            apply(0,0,0,2'd2,1,3'd0,8'd2);
            check("bounce_load", 3'd0, 0, 0, 0);
            apply(1,0,0,2'd2,0,3'd0,8'd2);
            check("bounce_start", 3'd0, 0, 0, 1);
            prev = 3'd0;
            for (int k = 0; k < 14; k++) begin
                for (int c = 0; c < 2; c++) begin
                    apply(0,0,0,2'd2,0,3'd0,8'd2);
                    check($sformatf("bounce_wait%0d_%0d", k, c), prev, 0, 0, 1);
                end
                apply(0,0,0,2'd2,0,3'd0,8'd2);
                check($sformatf("bounce_step%0d", k), seq[k], 1, (k == 13), 1);
                prev = seq[k];
            end
            apply(0,1,0,2'd2,0,3'd0,8'd2);
            check("bounce_stop", 3'd0, 0, 0, 0);
        end

        // load coinciding with a due step, div=2
        apply(1,0,0,2'd0,0,3'd0,8'd2);
        check("ldstep_start", 3'd0, 0, 0, 1);
        apply(0,0,0,2'd0,0,3'd0,8'd2);
        apply(0,0,0,2'd0,0,3'd0,8'd2);
        apply(0,0,0,2'd0,0,3'd0,8'd2);
        check("ldstep_first", 3'd1, 1, 0, 1);
        apply(0,0,0,2'd0,0,3'd0,8'd2);
        apply(0,0,0,2'd0,0,3'd0,8'd2);
        check("ldstep_pre", 3'd1, 0, 0, 1);
        apply(0,0,0,2'd0,1,3'd5,8'd2);
        check("ldstep_load", 3'd5, 0, 0, 1);
        apply(0,0,0,2'd0,0,3'd0,8'd2);
        check("ldstep_w1", 3'd5, 0, 0, 1);
        apply(0,0,0,2'd0,0,3'd0,8'd2);
        check("ldstep_w2", 3'd5, 0, 0, 1);
        apply(0,0,0,2'd0,0,3'd0,8'd2);
        check("ldstep_next", 3'd6, 1, 0, 1);
        apply(0,1,0,2'd0,0,3'd0,8'd2);
        check("ldstep_stop", 3'd6, 0, 0, 0);

        // asynchronous reset mid-run
        apply(1,0,0,2'd0,0,3'd0,8'd0);
        apply(0,0,0,2'd0,0,3'd0,8'd0);
        apply(0,0,0,2'd0,0,3'd0,8'd0);
        check("arst_pre", 3'd0, 1, 1, 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_async", 3'd0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply(0,0,0,2'd0,0,3'd0,8'd0);
            check($sformatf("arst_quiet%0d", i), 3'd0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
